updown_driver: RTL

//   Instruction-side partner of the 1-bit up/down counter. Accepts target values over a

---
 rtl/updown_driver.sv | 120 ++++++++++++
 1 files changed

// File: rtl/updown_driver.sv
// updown_driver
//   Instruction-side partner of a 1-bit up/down counter. Takes target values over
//   a valid/ready handshake. Each cycle it emits the inst bit (0 = up, 1 = down)
//   that steers the counter toward the target along the shortest modular path.
//   It keeps a shadow copy of the counter value, which moves every cycle, so once
//   the target is reached the value dithers around it.
//
//   Optional feature macro: UPDOWN_DRIVER_CHECK_EN
//     When this macro is defined, the module gains the value_in/mismatch ports and
//     a sticky compare of the real counter value against the shadow copy.
//
// Ports
//   clock         in   1      rising-edge clock, shared with the counter
//   reset         in   1      synchronous, active-high, shared with the counter
//   cmd_valid     in   1      cmd_target is valid
//   cmd_ready     out  1      command can be accepted (HOLD and not in reset)
//   cmd_target    in   WIDTH  requested counter value
//   inst          out  1      registered instruction to the counter
//   shadow_value  out  WIDTH  registered model of the counter value
//   busy          out  1      high while seeking
//   arrived       out  1      one-cycle pulse when the shadow reaches the target
//   value_in      in   WIDTH  counter value (UPDOWN_DRIVER_CHECK_EN only)
//   mismatch      out  1      sticky shadow/counter disagreement (UPDOWN_DRIVER_CHECK_EN only)

module updown_driver #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    output logic             inst,
    output logic [WIDTH-1:0] shadow_value,
    output logic             busy,
    output logic             arrived
`ifdef UPDOWN_DRIVER_CHECK_EN
    ,
    input  logic [WIDTH-1:0] value_in,
    output logic             mismatch
`endif
);

    typedef enum logic {
        HOLD = 1'b0,
        SEEK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             inst_q, inst_d;
    logic             arrived_q, arrived_d;
    logic             accept;
    logic [WIDTH-1:0] diff;

    assign cmd_ready = (state_q == HOLD) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        shadow_d  = inst_q ? (shadow_q - 1'b1) : (shadow_q + 1'b1);
        // A newly accepted target steers on the edge that accepts it.
        target_d  = accept ? cmd_target : target_q;
        // The sign bit of the wrapped difference selects the shorter direction.
        // An exact half-range tie has the MSB set and therefore steers down.
        diff      = target_d - shadow_d;
        inst_d    = diff[WIDTH-1];
        state_d   = state_q;
        arrived_d = 1'b0;
        if (accept || (state_q == SEEK)) begin
            // A command that is already satisfied enters and leaves SEEK on the same edge.
            if (shadow_d == target_d) begin
                state_d   = HOLD;
                arrived_d = 1'b1;
            end else begin
                state_d   = SEEK;
            end
        end
    end

`ifdef UPDOWN_DRIVER_CHECK_EN
    logic mismatch_q, mismatch_d;

    always_comb begin
        mismatch_d = mismatch_q | (value_in != shadow_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= HOLD;
            shadow_q  <= '0;
            target_q  <= '0;
            inst_q    <= 1'b0;
            arrived_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            target_q  <= target_d;
            inst_q    <= inst_d;
            arrived_q <= arrived_d;
        end
    end

    assign inst         = inst_q;
    assign shadow_value = shadow_q;
    assign busy         = (state_q == SEEK);
    assign arrived      = arrived_q;

endmodule
